// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32 memory-access stage: ALU pass-through, data-bus load/store FSM, load alignment
// Stalls upstream for the whole bus transaction and writes a bubble on every stalled edge.
module mem_stage #(
  parameter int RADDR_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic               reg_we_i,
  input  logic [DATA_W-1:0]  reg_wdata_i,
  input  logic [1:0]         mem_op_i,
  input  logic [1:0]         mem_size_i,
  input  logic               mem_unsigned_i,
  input  logic [DATA_W-1:0]  mem_addr_i,
  input  logic [DATA_W-1:0]  mem_sdata_i,
  output logic               stall_o,
  output logic               dbus_req_o,
  output logic               dbus_we_o,
  output logic [DATA_W-1:0]  dbus_addr_o,
  output logic [3:0]         dbus_be_o,
  output logic [DATA_W-1:0]  dbus_wdata_o,
  input  logic               dbus_gnt_i,
  input  logic               dbus_rvalid_i,
  input  logic [DATA_W-1:0]  dbus_rdata_i,
  output logic               mem_err_o,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic               reg_we_o,
  output logic [DATA_W-1:0]  reg_wdata_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  state_e state_q, state_d;

  logic              is_load, is_store, acc_err, acc_ok;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata, shifted, ldata_ext;
  logic              stall, capture, gnt_take, rsp_take;

  logic              req_q, we_q;
  logic [DATA_W-1:0] addr_q, wdata_q, ldata_q;
  logic [3:0]        be_q;

  logic [RADDR_W-1:0] rwaddr_q;
  logic               rwe_q, rwe_d, err_q;
  logic [DATA_W-1:0]  rwdata_q, rwdata_d;

  assign is_load  = (mem_op_i == 2'b01);
  assign is_store = (mem_op_i == 2'b10);
  assign acc_err  = (is_load | is_store) &
                    ((mem_size_i == 2'b11) |
                     ((mem_size_i == 2'b01) & mem_addr_i[0]) |
                     ((mem_size_i == 2'b10) & (mem_addr_i[1:0] != 2'b00)));
  assign acc_ok   = (is_load | is_store) & ~acc_err;

  always_comb begin
    be    = 4'b0000;
    wdata = mem_sdata_i;
    case (mem_size_i)
      2'b00: begin
        be    = 4'b0001 << mem_addr_i[1:0];
        wdata = {4{mem_sdata_i[7:0]}};
      end
      2'b01: begin
        be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_sdata_i[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend to the full word.
  assign shifted = dbus_rdata_i >> {mem_addr_i[1:0], 3'b000};

  always_comb begin
    ldata_ext = shifted;
    case (mem_size_i)
      2'b00:   ldata_ext = {{(DATA_W-8){~mem_unsigned_i & shifted[7]}}, shifted[7:0]};
      2'b01:   ldata_ext = {{(DATA_W-16){~mem_unsigned_i & shifted[15]}}, shifted[15:0]};
      default: ldata_ext = shifted;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_ok) state_d = REQ;
      REQ:     if (dbus_gnt_i) state_d = is_load ? WAIT : DONE;
      WAIT:    if (dbus_rvalid_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    capture  = 1'b0;
    gnt_take = 1'b0;
    rsp_take = 1'b0;
    case (state_q)
      IDLE: begin
        stall   = acc_ok;
        capture = acc_ok;
      end
      REQ: begin
        stall    = 1'b1;
        gnt_take = dbus_gnt_i;
      end
      WAIT: begin
        stall    = 1'b1;
        rsp_take = dbus_rvalid_i;
      end
      default: stall = 1'b0;
    endcase
  end

  assign stall_o = stall & rst_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
    end else if (capture) begin
      req_q   <= 1'b1;
      we_q    <= is_store;
      addr_q  <= {mem_addr_i[DATA_W-1:2], 2'b00};
      be_q    <= be;
      wdata_q <= wdata;
    end else if (gnt_take) begin
      req_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        ldata_q <= '0;
    else if (rsp_take) ldata_q <= ldata_ext;
  end

  // Only a completing load (in DONE) substitutes bus data for the ALU result.
  always_comb begin
    rwe_d   = reg_we_i & ~is_store & ~acc_err;
    rwdata_d = ((state_q == DONE) && is_load) ? ldata_q : reg_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rwaddr_q <= '0;
      rwe_q    <= 1'b0;
      rwdata_q <= '0;
      err_q    <= 1'b0;
    end else if (stall) begin
      rwe_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rwaddr_q <= reg_waddr_i;
      rwe_q    <= rwe_d;
      rwdata_q <= rwdata_d;
      err_q    <= acc_err;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign mem_err_o    = err_q;
  assign reg_waddr_o  = rwaddr_q;
  assign reg_we_o     = rwe_q;
  assign reg_wdata_o  = rwdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a behavioural bus/writeback model
module tb_mem_stage;
  localparam int RADDR_W = 5;
  localparam int DATA_W  = 32;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [RADDR_W-1:0] reg_waddr_i = '0;
  logic               reg_we_i = 1'b0;
  logic [DATA_W-1:0]  reg_wdata_i = '0;
  logic [1:0]         mem_op_i = 2'b00;
  logic [1:0]         mem_size_i = 2'b00;
  logic               mem_unsigned_i = 1'b0;
  logic [DATA_W-1:0]  mem_addr_i = '0;
  logic [DATA_W-1:0]  mem_sdata_i = '0;
  logic               stall_o;
  logic               dbus_req_o, dbus_we_o;
  logic [DATA_W-1:0]  dbus_addr_o, dbus_wdata_o;
  logic [3:0]         dbus_be_o;
  logic               dbus_gnt_i = 1'b0;
  logic               dbus_rvalid_i = 1'b0;
  logic [DATA_W-1:0]  dbus_rdata_i = '0;
  logic               mem_err_o;
  logic [RADDR_W-1:0] reg_waddr_o;
  logic               reg_we_o;
  logic [DATA_W-1:0]  reg_wdata_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_stage #(.RADDR_W(RADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_op_i(mem_op_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .stall_o(stall_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .mem_err_o(mem_err_o),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o)
  );

  function automatic logic m_is_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] sdata);
    if (size == 2'd0) return 32'(sdata % 256) * 32'h01010101;
    if (size == 2'd1) return 32'(sdata % 65536) * 32'h00010001;
    return sdata;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * (addr % 4));
    if (size == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // Entered and left just after a rising edge; plays the bus slave with the given delays.
  task automatic run_access(input logic [1:0] op, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input logic [4:0] waddr, input logic we,
                            input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                            input string name);
    logic ld, st, err, granted, real_gnt, rv, fields_ok, bubble_ok, done;
    int stalls, reqs, since_gnt, exp_stalls, exp_reqs;
    logic [31:0] exp_wd;
    ld  = (op == 2'd1);
    st  = (op == 2'd2);
    err = (ld || st) && m_is_err(size, addr);
    if (err) begin ld = 1'b0; st = 1'b0; end
    exp_stalls = ld ? 3 + gnt_dly + rv_dly : (st ? 2 + gnt_dly : 0);
    exp_reqs   = (ld || st) ? gnt_dly + 1 : 0;
    exp_wd     = ld ? m_load(size, uns, addr, rdata) : wdata;
    reg_waddr_i = waddr; reg_we_i = we; reg_wdata_i = wdata;
    mem_op_i = op; mem_size_i = size; mem_unsigned_i = uns;
    mem_addr_i = addr; mem_sdata_i = sdata;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    stalls = 0; reqs = 0; since_gnt = 0;
    granted = 1'b0; fields_ok = 1'b1; bubble_ok = 1'b1; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk_i);
      if (dbus_req_o) begin
        reqs++;
        if (dbus_we_o !== st || dbus_addr_o !== {addr[31:2], 2'b00} ||
            dbus_be_o !== m_be(size, addr) || (st && dbus_wdata_o !== m_wdata(size, sdata)))
          fields_ok = 1'b0;
      end
      if (stall_o) begin
        stalls++;
        if (stalls > 1 && reg_we_o !== 1'b0) bubble_ok = 1'b0;
      end else begin
        done = 1'b1;
      end
      real_gnt = dbus_req_o && !granted && (reqs == gnt_dly + 1);
      if (granted) since_gnt++;
      rv = granted && ld && (since_gnt == rv_dly + 1);
      dbus_gnt_i    = real_gnt | (granted & 1'($urandom_range(0, 1)));
      dbus_rvalid_i = rv | (dbus_req_o & 1'($urandom_range(0, 1)));
      dbus_rdata_i  = rv ? rdata : $urandom;
      if (real_gnt) granted = 1'b1;
    end
    @(posedge clk_i);
    #1;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    checks++;
    if (stalls !== exp_stalls) begin
      errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stalls);
    end
    checks++;
    if (reqs !== exp_reqs) begin
      errors++; $display("FAIL %s req_cycles: got %0d expected %0d", name, reqs, exp_reqs);
    end
    checks++;
    if (dbus_req_o !== 1'b0) begin
      errors++; $display("FAIL %s req_after: got %b expected 0", name, dbus_req_o);
    end
    checks++;
    if (mem_err_o !== err) begin
      errors++; $display("FAIL %s mem_err: got %b expected %b", name, mem_err_o, err);
    end
    checks++;
    if (reg_we_o !== (we & ~st & ~err)) begin
      errors++; $display("FAIL %s reg_we: got %b expected %b", name, reg_we_o, we & ~st & ~err);
    end
    if (ld || st) begin
      checks++;
      if (fields_ok !== 1'b1) begin
        errors++; $display("FAIL %s bus_fields: got mismatch expected be %h addr %h", name,
                           m_be(size, addr), {addr[31:2], 2'b00});
      end
      checks++;
      if (bubble_ok !== 1'b1) begin
        errors++; $display("FAIL %s bubble: got reg_we high while stalled expected 0", name);
      end
    end
    if (!st) begin
      checks++;
      if (reg_waddr_o !== waddr) begin
        errors++; $display("FAIL %s reg_waddr: got %0d expected %0d", name, reg_waddr_o, waddr);
      end
      checks++;
      if (reg_wdata_o !== exp_wd) begin
        errors++; $display("FAIL %s reg_wdata: got %h expected %h", name, reg_wdata_o, exp_wd);
      end
    end
  endtask

  task automatic test_reset;
    mem_op_i = 2'd1; mem_size_i = 2'd2; mem_addr_i = 32'h100; reg_we_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if ({stall_o, dbus_req_o, reg_we_o, mem_err_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {stall_o, dbus_req_o, reg_we_o, mem_err_o});
    end
    checks++;
    if (reg_wdata_o !== 32'h0 || reg_waddr_o !== 5'd0) begin
      errors++; $display("FAIL reset_data: got %h/%0d expected 0/0", reg_wdata_o, reg_waddr_o);
    end
    mem_op_i = 2'd0; reg_we_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  task automatic test_nonmem;
    run_access(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h12345678, 0, 0, "nonmem");
  endtask

  task automatic test_load;
    run_access(2'd1, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FFFFFF, 5'd6, 1'b1, 32'h0, 0, 0, "lb");
    run_access(2'd1, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FFFFFF, 5'd6, 1'b1, 32'h0, 0, 0, "lbu");
    run_access(2'd1, 2'd1, 1'b0, 32'h1002, 32'h0, 32'h9234ABCD, 5'd8, 1'b1, 32'h0, 1, 2, "lh");
  endtask

  task automatic test_store;
    run_access(2'd2, 2'd1, 1'b0, 32'h2002, 32'hAAAABEEF, 32'h0, 5'd4, 1'b1, 32'h0, 2, 0, "sh");
    run_access(2'd2, 2'd0, 1'b0, 32'h2001, 32'h000000A5, 32'h0, 5'd4, 1'b1, 32'h0, 0, 0, "sb");
  endtask

  task automatic test_error;
    run_access(2'd1, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 5'd9, 1'b1, 32'h55AA55AA, 0, 0, "lw_misaligned");
    run_access(2'd1, 2'd3, 1'b0, 32'h3000, 32'h0, 32'h0, 5'd9, 1'b1, 32'h55AA55AA, 0, 0, "illegal_size");
    run_access(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 32'h00000077, 0, 0, "after_error");
  endtask

  task automatic test_back_to_back;
    run_access(2'd1, 2'd2, 1'b0, 32'h10, 32'h0, 32'h11112222, 5'd10, 1'b1, 32'h0, 0, 0, "lw_0x10");
    run_access(2'd1, 2'd2, 1'b0, 32'h14, 32'h0, 32'h33334444, 5'd11, 1'b1, 32'h0, 0, 0, "lw_0x14");
  endtask

  task automatic test_reset_mid;
    reg_waddr_i = 5'd7; reg_we_i = 1'b1; mem_op_i = 2'd1; mem_size_i = 2'd2; mem_addr_i = 32'h40;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (dbus_req_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_req: got %b expected 1", dbus_req_o);
    end
    dbus_gnt_i = 1'b1;
    @(posedge clk_i);
    #1 dbus_gnt_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if ({stall_o, dbus_req_o, reg_we_o, mem_err_o} !== 4'b0000 || reg_wdata_o !== 32'h0) begin
      errors++; $display("FAIL rstmid_outputs: got %b/%h expected 0000/0",
                         {stall_o, dbus_req_o, reg_we_o, mem_err_o}, reg_wdata_o);
    end
    mem_op_i = 2'd0; reg_we_i = 1'b0; reg_wdata_i = 32'hCAFE0001; reg_waddr_i = 5'd3;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hDEADBEEF;
    reg_we_i = 1'b1; reg_wdata_i = 32'h0BADF00D; reg_waddr_i = 5'd9;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0 || dbus_req_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got stall %b req %b expected 0 0", stall_o, dbus_req_o);
    end
    @(posedge clk_i);
    #1 dbus_rvalid_i = 1'b0;
    checks++;
    if (reg_wdata_o !== 32'h0BADF00D || reg_we_o !== 1'b1 || reg_waddr_o !== 5'd9) begin
      errors++; $display("FAIL rstmid_drop: got %h/%b/%0d expected 0badf00d/1/9",
                         reg_wdata_o, reg_we_o, reg_waddr_o);
    end
    run_access(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1, 32'h600DCAFE, 0, 0, "rstmid_next");
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      run_access(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset;
    test_nonmem;
    test_load;
    test_store;
    test_error;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
